stdp_synapse: RTL and testbench

Single plastic synapse that drives the 8-bit input current of a leaky integrate-and-fire neuron. It turns incoming presynaptic spikes into an exponentially decaying synaptic current scaled by a learned weight. It adapts that weight with pair-based STDP using the neuron's own output spike fed back as the postsynaptic event. One instance sits in front of each neuron input; chains of neuron → synapse → neuron form the network.

---
 rtl/snn_pkg.sv | 46 ++++
 rtl/spike_trace.sv | 35 +++
 rtl/stdp_synapse.sv | 93 +++++++++
 tb/tb_stdp_synapse.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// Shared fixed-point helpers for the spiking network: value widths, the
// exponential-style decay rule and saturating/clamping arithmetic.
package snn_pkg;

  localparam int VAL_W   = 8;
  localparam int ARITH_W = 10;

  typedef logic [VAL_W-1:0]          val_t;
  typedef logic signed [ARITH_W-1:0] arith_t;

  localparam val_t VAL_MAX = 8'd255;

  // Decay by x>>shift, falling back to a unit step so every value reaches zero.
  function automatic val_t decay(input val_t x, input int shift);
    val_t d;
    d = x >> shift;
    if (x == 8'd0) begin
      return 8'd0;
    end else if (d == 8'd0) begin
      return x - 8'd1;
    end else begin
      return x - d;
    end
  endfunction

  function automatic val_t sat_add(input val_t a, input val_t b);
    logic [VAL_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s[VAL_W]) begin
      return VAL_MAX;
    end else begin
      return s[VAL_W-1:0];
    end
  endfunction

  function automatic val_t clamp_val(input arith_t v, input arith_t lo, input arith_t hi);
    if (v < lo) begin
      return val_t'(lo);
    end else if (v > hi) begin
      return val_t'(hi);
    end else begin
      return val_t'(v);
    end
  endfunction

endpackage

// File: rtl/spike_trace.sv
// Eligibility trace: reloads to full scale on a spike, otherwise decays
// toward zero with the shared decay rule.
module spike_trace
  import snn_pkg::*;
#(
  parameter int TAU_SHIFT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spike,
  output logic [7:0] trace
);

  val_t trace_next;

  // Next trace value: reload on spike, decay otherwise.
  always_comb begin
    trace_next = 8'd0;
    if (spike) begin
      trace_next = VAL_MAX;
    end else begin
      trace_next = decay(trace, TAU_SHIFT);
    end
  end

  // Trace register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trace <= 8'd0;
    end else begin
      trace <= trace_next;
    end
  end

endmodule

// File: rtl/stdp_synapse.sv
// Plastic synapse: decaying synaptic current scaled by a weight that is
// adapted by pair-based STDP from pre/post spike traces.
module stdp_synapse
  import snn_pkg::*;
#(
  parameter int W_INIT    = 64,
  parameter int W_MIN     = 0,
  parameter int W_MAX     = 255,
  parameter int TAU_SHIFT = 2,
  parameter int CUR_SHIFT = 1,
  parameter int LTP_SHIFT = 3,
  parameter int LTD_SHIFT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       learn_en,
  input  logic       pre_spike,
  input  logic       post_spike,
  output logic [7:0] current,
  output logic [7:0] weight,
  output logic [7:0] pre_trace,
  output logic [7:0] post_trace
);

  arith_t ltp;
  arith_t ltd;
  arith_t w_sum;
  val_t   weight_next;
  val_t   current_next;
  val_t   pre_drive;

  spike_trace #(.TAU_SHIFT(TAU_SHIFT)) u_pre_trace (
    .clk   (clk),
    .rst   (rst),
    .spike (pre_spike),
    .trace (pre_trace)
  );

  spike_trace #(.TAU_SHIFT(TAU_SHIFT)) u_post_trace (
    .clk   (clk),
    .rst   (rst),
    .spike (post_spike),
    .trace (post_trace)
  );

  // STDP update from the registered (pre-reload) traces; clamped once.
  always_comb begin
    ltp         = 10'sd0;
    ltd         = 10'sd0;
    w_sum       = 10'sd0;
    weight_next = weight;
    if (post_spike) begin
      ltp = arith_t'({2'b00, val_t'(pre_trace >> LTP_SHIFT)});
    end else begin
      ltp = 10'sd0;
    end
    if (pre_spike) begin
      ltd = arith_t'({2'b00, val_t'(post_trace >> LTD_SHIFT)});
    end else begin
      ltd = 10'sd0;
    end
    w_sum = arith_t'({2'b00, weight}) + ltp - ltd;
    if (learn_en) begin
      weight_next = clamp_val(w_sum, arith_t'(W_MIN), arith_t'(W_MAX));
    end else begin
      weight_next = weight;
    end
  end

  // Synaptic current: decay plus the pre-update weight on a presynaptic spike.
  always_comb begin
    pre_drive    = 8'd0;
    current_next = 8'd0;
    if (pre_spike) begin
      pre_drive = weight;
    end else begin
      pre_drive = 8'd0;
    end
    current_next = sat_add(decay(current, CUR_SHIFT), pre_drive);
  end

  // Weight and current registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      weight  <= val_t'(W_INIT);
      current <= 8'd0;
    end else begin
      weight  <= weight_next;
      current <= current_next;
    end
  end

endmodule

// File: tb/tb_stdp_synapse.sv
// Scoreboard bench for stdp_synapse: directed spike patterns with
// hand-computed expected outputs, checked by an independent monitor.
module tb_stdp_synapse;

  logic       clk;
  logic       rst;
  logic       learn_en;
  logic       pre_spike;
  logic       post_spike;
  logic [7:0] current;
  logic [7:0] weight;
  logic [7:0] pre_trace;
  logic [7:0] post_trace;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string tag;
    int    c;
    int    w;
    int    pt;
    int    qt;
  } exp_t;

  exp_t sb[$];

  int pt_seq[21]  = '{255, 192, 144, 108, 81, 61, 46, 35, 27, 21, 16,
                      12, 9, 7, 6, 5, 4, 3, 2, 1, 0};
  int cur_seq[21] = '{64, 32, 16, 8, 4, 2, 1, 0, 0, 0, 0,
                      0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  int hold_cur[11] = '{96, 128, 160, 192, 224, 255, 255, 255, 255, 255, 255};
  int hold_w[11]   = '{80, 96, 112, 128, 144, 160, 176, 192, 208, 224, 240};
  int low_w[5]     = '{49, 34, 19, 4, 0};

  stdp_synapse dut (
    .clk        (clk),
    .rst        (rst),
    .learn_en   (learn_en),
    .pre_spike  (pre_spike),
    .post_spike (post_spike),
    .current    (current),
    .weight     (weight),
    .pre_trace  (pre_trace),
    .post_trace (post_trace)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock of stimulus; a negative expectation means "don't care".
  task automatic step(input string tag, input logic p, input logic po, input logic l,
                      input int c, input int w, input int pt, input int qt);
    exp_t e;
    @(negedge clk);
    pre_spike  = p;
    post_spike = po;
    learn_en   = l;
    @(posedge clk);
    if (c >= 0 || w >= 0 || pt >= 0 || qt >= 0) begin
      e.tag = tag; e.c = c; e.w = w; e.pt = pt; e.qt = qt;
      sb.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step("idle", 1'b0, 1'b0, 1'b0, -1, -1, -1, -1);
  endtask

  // Asynchronous reset between edges, with spikes asserted to show they are ignored.
  task automatic do_reset(input string tag);
    @(negedge clk);
    pre_spike = 1'b1; post_spike = 1'b1; learn_en = 1'b1;
    #2 rst = 1'b1;
    #1;
    check({tag, "_current"}, current, 0);
    check({tag, "_weight"}, weight, 64);
    check({tag, "_pre_trace"}, pre_trace, 0);
    check({tag, "_post_trace"}, post_trace, 0);
    @(negedge clk);
    pre_spike = 1'b0; post_spike = 1'b0; learn_en = 1'b0;
    rst = 1'b0;
  endtask

  // Monitor: compare every pending expectation once outputs have settled.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.c  >= 0) check({e.tag, "_current"}, current, e.c);
        if (e.w  >= 0) check({e.tag, "_weight"}, weight, e.w);
        if (e.pt >= 0) check({e.tag, "_pre_trace"}, pre_trace, e.pt);
        if (e.qt >= 0) check({e.tag, "_post_trace"}, post_trace, e.qt);
      end
    end
  end

  initial begin
    clk = 1'b0; rst = 1'b1;
    learn_en = 1'b0; pre_spike = 1'b0; post_spike = 1'b0;
    #1;
    check("por_current", current, 0);
    check("por_weight", weight, 64);
    check("por_pre_trace", pre_trace, 0);
    check("por_post_trace", post_trace, 0);
    @(negedge clk);
    rst = 1'b0;

    // Decay of trace and current from a single presynaptic spike, no learning.
    step("decay", 1'b1, 1'b0, 1'b0, cur_seq[0], 64, pt_seq[0], 0);
    for (int i = 1; i < 21; i++)
      step("decay", 1'b0, 1'b0, 1'b0, cur_seq[i], 64, pt_seq[i], 0);

    // Causal pair: pre then post gives LTP of 31.
    do_reset("rst_a");
    step("ltp_pre", 1'b1, 1'b0, 1'b1, 64, 64, 255, 0);
    step("ltp_post", 1'b0, 1'b1, 1'b1, 32, 95, 192, 255);

    // Asynchronous reset mid-burst with a learned weight.
    do_reset("rst_mid");
    step("holdoff", 1'b0, 1'b0, 1'b0, 0, 64, 0, 0);

    // Anti-causal pair: post then pre gives LTD of 15; current uses old weight.
    step("ltd_post", 1'b0, 1'b1, 1'b1, 0, 64, 0, 255);
    step("ltd_pre", 1'b1, 1'b0, 1'b1, 64, 49, 255, 192);

    // Simultaneous spikes with full traces (+16 net), saturation, upper clamp.
    do_reset("rst_b");
    step("sim_load", 1'b1, 1'b1, 1'b0, 64, 64, 255, 255);
    for (int i = 0; i < 11; i++)
      step("sim_hold", 1'b1, 1'b1, 1'b1, hold_cur[i], hold_w[i], 255, 255);
    step("clamp_hi", 1'b0, 1'b1, 1'b1, 128, 255, 192, 255);

    // Repeated pure LTD until the lower clamp.
    do_reset("rst_c");
    for (int r = 0; r < 5; r++) begin
      step("low_post", 1'b0, 1'b1, 1'b1, -1, -1, -1, -1);
      step("clamp_lo", 1'b1, 1'b0, 1'b1, -1, low_w[r], 255, 192);
      idle(16);
    end

    // Learning disabled: traces load, weight holds.
    do_reset("rst_d");
    step("gate_pre", 1'b1, 1'b0, 1'b0, 64, 64, 255, 0);
    step("gate_post", 1'b0, 1'b1, 1'b0, 32, 64, 192, 255);
    step("gate_pre2", 1'b1, 1'b0, 1'b0, 80, 64, 255, 192);

    @(negedge clk);
    #1;
    check("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
